wbm_rr_arbiter: RTL and testbench
=================================

// Module: wbm_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WISHBONE target bus between NUM_MASTERS initiators.
//  Grant is held for a master's entire bus cycle (cyc high), then rotates fairly.
//  Sits between initiators (register cores, DMA, UART bridges) and the interconnect
//  fabric, whose unused target ports are closed off with dummy slaves.
// PARAMETERS
//  NUM_MASTERS    4    number of initiators, 2..8
//  ADDRESS_WIDTH  16   WB address width
//  DATA_WIDTH     32   WB data width, multiple of 8
//  TIMEOUT_CYCLES 255  stb-without-response cycles before abort (WBARB_TIMEOUT_EN only)
// PORTS  (N=NUM_MASTERS, AW=ADDRESS_WIDTH, DW=DATA_WIDTH)
//  clk_i       in   1        clock
//  rst_i       in   1        reset, asynchronous, active-high
//  m_cyc_i     in   N        per-master cyc
//  m_stb_i     in   N        per-master stb
//  m_we_i      in   N        per-master we
//  m_adr_i     in   N*AW     packed addresses, master k at [k*AW +: AW]
//  m_dat_i     in   N*DW     packed write data
//  m_sel_i     in   N*DW/8   packed byte selects
//  m_dat_o     out  DW       read data, broadcast to all masters
//  m_ack_o     out  N        ack, only to granted master
//  m_err_o     out  N        err, only to granted master
//  m_rty_o     out  N        rty, only to granted master
//  s_cyc_o/s_stb_o/s_we_o  out 1   target cyc/stb/we
//  s_adr_o out AW; s_dat_o out DW; s_sel_o out DW/8   target address/data/select
//  s_dat_i in DW; s_ack_i/s_err_i/s_rty_i in 1        target responses
//  grant_o     out  N        registered one-hot grant, 0 when idle
// BEHAVIOUR
//  - Reset: grant_o=0, state IDLE, rr pointer=N-1 (master 0 wins first); all s_*_o and
//    m_ack/err/rty_o=0 combinationally; timeout counter=0. Reset mid-cycle drops everything.
//  - FSM IDLE: if any m_cyc_i, register grant to first requester after pointer (wrapping),
//    go OWN. One-cycle arbitration latency: s_cyc_o rises the cycle after m_cyc_i.
//  - FSM OWN: s_* = granted master's signals (comb mux), s_cyc_o=m_cyc_i[g]&grant.
//    s_ack/err/rty_i routed to bit g only; other masters see 0. m_dat_o=s_dat_i always.
//  - OWN exits when m_cyc_i[g]=0: grant cleared, pointer=g, back to IDLE (one dead cycle
//    between owners; target sees cyc low at least one cycle).
//  - Simultaneous requests resolved purely by rotation; a master requesting continuously
//    waits at most N-1 other bus cycles. Requests arriving during OWN are not lost; level held.
//  - Master dropping cyc mid-transfer: target sees cyc/stb drop same cycle; legal abort.
//  - Late/stray target responses while IDLE are dropped (no master receives them).
// CONFIGURATION
//  WBARB_TIMEOUT_EN defined: counter increments each OWN cycle with s_stb_o high and
//   no ack/err/rty; cleared by any response or stb low. At count==TIMEOUT_CYCLES: one-cycle
//   m_err_o[g], s_cyc_o/s_stb_o forced 0, FSM -> ABORT; ABORT holds s_cyc_o=0 until
//   m_cyc_i[g]=0, then IDLE with pointer=g.
//  Not defined: no counter, no ABORT state; an unresponsive target stalls the bus forever.
// STRUCTURE
//  - wbarb_defs.vh: FSM state encodings (IDLE/OWN/ABORT), a clog2-style width function, packed-
//    slice helper macros; reused by other interconnect blocks.
//  - Sub-module rr_priority_select: comb, inputs req[N], ptr index; outputs one-hot next grant
//    and its index. Arbiter holds FSM, pointer, grant reg, muxes, timeout counter.
// TESTING
//  - Reset then m_cyc_i=4'b0001 single write adr 0x0010 -> grant_o=0001 next cycle, s_adr_o=0x0010,
//    ack to m_ack_o[0] only.
//  - m_cyc_i=4'b1111 held, each master one access per cycle -> grant order 0,1,2,3,0; one idle cyc gap.
//  - Master 2 owns with 3-beat burst while master 1 requests -> grant stays 0100 for all 3 acks, then 0010.
//  - rst_i pulsed mid-OWN with s_stb_o high -> all outputs 0 asynchronously, next grant goes to master 0.
//  - Target never acks, TIMEOUT_CYCLES=8, macro on -> m_err_o[g] pulses on 8th stall cycle, s_cyc_o low;
//    macro off -> stb held indefinitely, no err.
//  - Stray s_ack_i while IDLE -> m_ack_o stays 4'b0000.

Source files
------------

// File: rtl/wbm_rr_arbiter_pkg.sv
// Shared definitions for the WISHBONE round-robin arbiter: FSM states and index-width helper.
package wbm_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wbm_rr_arbiter_rr_priority_select.sv
// Rotating priority pick: first requester strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_priority_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        k       = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!gnt_vld && req[k]) begin
                gnt_vld    = 1'b1;
                gnt[k]     = 1'b1;
                gnt_idx    = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/wbm_rr_arbiter.sv
// Round-robin WISHBONE arbiter; grant held for a whole cyc, one dead cycle between owners.
// Latency: one cycle request-to-grant; target signals muxed combinationally while owning.
// Backpressure: waiting masters hold cyc; optional WBARB_TIMEOUT_EN aborts a stalled target.
module wbm_rr_arbiter
    import wbm_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_MASTERS-1:0]                    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                    m_stb_i,
    input  logic [NUM_MASTERS-1:0]                    m_we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]      m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]         m_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]     m_sel_i,
    output logic [DATA_WIDTH-1:0]                     m_dat_o,
    output logic [NUM_MASTERS-1:0]                    m_ack_o,
    output logic [NUM_MASTERS-1:0]                    m_err_o,
    output logic [NUM_MASTERS-1:0]                    m_rty_o,
    output logic                                      s_cyc_o,
    output logic                                      s_stb_o,
    output logic                                      s_we_o,
    output logic [ADDRESS_WIDTH-1:0]                  s_adr_o,
    output logic [DATA_WIDTH-1:0]                     s_dat_o,
    output logic [DATA_WIDTH/8-1:0]                   s_sel_o,
    input  logic [DATA_WIDTH-1:0]                     s_dat_i,
    input  logic                                      s_ack_i,
    input  logic                                      s_err_i,
    input  logic                                      s_rty_i,
    output logic [NUM_MASTERS-1:0]                    grant_o
);

    localparam int N  = NUM_MASTERS;
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = idx_width(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("wbm_rr_arbiter: unsupported parameter set");
    end

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] gidx, gidx_nxt;
    logic [N-1:0]  grant, grant_nxt;
    logic [N-1:0]  sel_gnt;
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    logic          own, g_cyc, g_stb, timeout_hit;

    rr_priority_select #(.N(N), .IW(IW)) u_sel (
        .req     (m_cyc_i),
        .ptr     (ptr),
        .gnt     (sel_gnt),
        .gnt_idx (sel_idx),
        .gnt_vld (sel_vld)
    );

    assign own   = (state == ST_OWN);
    assign g_cyc = m_cyc_i[gidx];
    assign g_stb = m_stb_i[gidx] & g_cyc;

`ifdef WBARB_TIMEOUT_EN
    localparam int CW = idx_width(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          stall;

    // Stall is judged on the master's raw strobe so the abort can gate s_stb_o without a loop.
    assign stall       = own & g_stb & ~(s_ack_i | s_err_i | s_rty_i);
    assign timeout_hit = stall && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= '0;
        else if (stall && !timeout_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            ptr   <= IW'(N - 1);
            gidx  <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gidx  <= gidx_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_nxt = sel_gnt;
                    gidx_nxt  = sel_idx;
                    state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!g_cyc) begin
                    grant_nxt = '0;
                    ptr_nxt   = gidx;
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ST_ABORT;
                end
            end
`ifdef WBARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!g_cyc) begin
                    grant_nxt = '0;
                    ptr_nxt   = gidx;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Target side follows the owner; responses never leak to a master while idle/aborting.
    assign s_cyc_o = own & ~timeout_hit & g_cyc;
    assign s_stb_o = own & ~timeout_hit & g_stb;
    assign s_we_o  = own & m_we_i[gidx];
    assign s_adr_o = own ? m_adr_i[gidx*AW +: AW] : '0;
    assign s_dat_o = own ? m_dat_i[gidx*DW +: DW] : '0;
    assign s_sel_o = own ? m_sel_i[gidx*SW +: SW] : '0;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = (own && s_ack_i) ? grant : '0;
    assign m_err_o = (own && (s_err_i || timeout_hit)) ? grant : '0;
    assign m_rty_o = (own && s_rty_i) ? grant : '0;
    assign grant_o = grant;

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Bench for wbm_rr_arbiter: vector table, hand-written corner sequences, randomized model check.
module tb_wbm_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]    grant_o;

    int vectors     = 0;
    int miscompares = 0;

    wbm_rr_arbiter #(
        .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          m;
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  resp;       // {ack, err, rty}
        logic [31:0] rdat;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_err;
        logic [3:0]  exp_rty;
    } vec_t;

    vec_t vec [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_bus();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = {$urandom, $urandom};
        m_dat_i = {$urandom, $urandom, $urandom, $urandom};
        m_sel_i = 16'($urandom);
        s_dat_i = $urandom;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_bus();
        step();
        step();
        rst_i = 1'b0;
    endtask

    function automatic int pick(input int p, input logic [3:0] req);
        for (int d = 1; d <= N; d++)
            if (req[(p + d) % N]) return (p + d) % N;
        return -1;
    endfunction

    initial begin
        vec[0] = '{0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b100, 32'h0,        4'b0001, 4'b0001, 4'b0000, 4'b0000};
        vec[1] = '{3, 1'b0, 16'hABCD, 32'h0,        4'h3, 3'b010, 32'h11112222, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
        vec[2] = '{1, 1'b1, 16'h1234, 32'h55AA55AA, 4'h5, 3'b001, 32'h0,        4'b0010, 4'b0000, 4'b0000, 4'b0010};
        vec[3] = '{2, 1'b0, 16'hFFFE, 32'h0,        4'hC, 3'b100, 32'hCAFEF00D, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        vec[4] = '{1, 1'b0, 16'h0000, 32'h0,        4'h1, 3'b000, 32'h0,        4'b0010, 4'b0000, 4'b0000, 4'b0000};

        // Reset state with masters already requesting.
        rst_i = 1'b1;
        clear_bus();
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        s_ack_i = 1'b1;
        step();
        step();
        @(negedge clk_i);
        chk("rst_grant", grant_o, 0);
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_m_ack", m_ack_o, 0);
        step();
        clear_bus();
        rst_i = 1'b0;
        step();

        // Single-master transactions from the table.
        for (int v = 0; v < 5; v++) begin
            clear_bus();
            m_cyc_i[vec[v].m] = 1'b1;
            m_stb_i[vec[v].m] = 1'b1;
            m_we_i[vec[v].m]  = vec[v].we;
            m_adr_i[vec[v].m*AW +: AW] = vec[v].adr;
            m_dat_i[vec[v].m*DW +: DW] = vec[v].dat;
            m_sel_i[vec[v].m*SW +: SW] = vec[v].sel;
            @(negedge clk_i);
            chk("tbl_arb_latency_grant", grant_o, 0);
            chk("tbl_arb_latency_cyc", s_cyc_o, 0);
            step();
            @(negedge clk_i);
            chk("tbl_grant", grant_o, vec[v].exp_grant);
            chk("tbl_s_cyc", s_cyc_o, 1);
            chk("tbl_s_stb", s_stb_o, 1);
            chk("tbl_s_we", s_we_o, vec[v].we);
            chk("tbl_s_adr", s_adr_o, vec[v].adr);
            chk("tbl_s_dat", s_dat_o, vec[v].dat);
            chk("tbl_s_sel", s_sel_o, vec[v].sel);
            {s_ack_i, s_err_i, s_rty_i} = vec[v].resp;
            s_dat_i = vec[v].rdat;
            #1;
            chk("tbl_m_ack", m_ack_o, vec[v].exp_ack);
            chk("tbl_m_err", m_err_o, vec[v].exp_err);
            chk("tbl_m_rty", m_rty_o, vec[v].exp_rty);
            chk("tbl_m_dat", m_dat_o, vec[v].rdat);
            step();
            clear_bus();
            @(negedge clk_i);
            chk("tbl_drop_cyc", s_cyc_o, 0);
            step();
            @(negedge clk_i);
            chk("tbl_idle_grant", grant_o, 0);
            step();
        end

        // Stray responses while idle.
        clear_bus();
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        s_rty_i = 1'b1;
        #1;
        chk("stray_ack", m_ack_o, 0);
        chk("stray_err", m_err_o, 0);
        chk("stray_rty", m_rty_o, 0);
        step();
        clear_bus();

        // All four request continuously; each does one access: order 0,1,2,3,0 with idle gaps.
        do_reset();
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        step();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk_i);
            chk("rr_grant", grant_o, 4'b0001 << (j % N));
            chk("rr_s_cyc", s_cyc_o, 1);
            s_ack_i = 1'b1;
            #1;
            chk("rr_ack", m_ack_o, 4'b0001 << (j % N));
            step();
            s_ack_i = 1'b0;
            m_cyc_i[j % N] = 1'b0;
            m_stb_i[j % N] = 1'b0;
            @(negedge clk_i);
            chk("rr_abort_cyc", s_cyc_o, 0);
            step();
            m_cyc_i[j % N] = 1'b1;
            m_stb_i[j % N] = 1'b1;
            @(negedge clk_i);
            chk("rr_gap", grant_o, 0);
            step();
        end
        clear_bus();
        step();
        step();

        // Master 2 bursts three beats while master 1 waits.
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        step();
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk_i);
            s_ack_i = 1'b1;
            #1;
            chk("burst_grant", grant_o, 4'b0100);
            chk("burst_ack", m_ack_o, 4'b0100);
            step();
        end
        s_ack_i = 1'b0;
        m_cyc_i[2] = 1'b0;
        m_stb_i[2] = 1'b0;
        step();
        @(negedge clk_i);
        chk("burst_gap", grant_o, 0);
        step();
        @(negedge clk_i);
        chk("burst_next", grant_o, 4'b0010);
        clear_bus();
        step();
        step();

        // Asynchronous reset mid-ownership.
        m_cyc_i = 4'b1000;
        m_stb_i = 4'b1000;
        step();
        @(negedge clk_i);
        chk("own3_grant", grant_o, 4'b1000);
        chk("own3_stb", s_stb_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_grant", grant_o, 0);
        chk("async_rst_cyc", s_cyc_o, 0);
        chk("async_rst_stb", s_stb_o, 0);
        step();
        rst_i = 1'b0;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        step();
        @(negedge clk_i);
        chk("post_rst_grant", grant_o, 4'b0001);

        // Unresponsive target.
        do_reset();
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        step();
`ifdef WBARB_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_i);
            chk("tmo_err", m_err_o, (i == 8) ? 4'b0010 : 4'b0000);
            chk("tmo_cyc", s_cyc_o, (i == 8) ? 1'b0 : 1'b1);
            step();
        end
        @(negedge clk_i);
        chk("abort_cyc", s_cyc_o, 0);
        chk("abort_err_once", m_err_o, 0);
        clear_bus();
        step();
        @(negedge clk_i);
        chk("abort_exit_grant", grant_o, 0);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("stall_stb", s_stb_o, 1);
            chk("stall_no_err", m_err_o, 0);
            step();
        end
        clear_bus();
        step();
`endif

        // Randomized traffic against a rotation model.
        do_reset();
        begin
            int   own = -1;
            int   ptr = N - 1;
            bit   busy [N];
            int   rem  [N];
            logic [3:0] exp_g;
            for (int k = 0; k < N; k++) begin
                busy[k] = 1'b0;
                rem[k]  = 0;
            end
            for (int c = 0; c < 500; c++) begin
                for (int k = 0; k < N; k++) begin
                    if (!busy[k] && $urandom_range(0, 2) == 0) begin
                        busy[k] = 1'b1;
                        rem[k]  = $urandom_range(1, 4);
                    end
                    m_cyc_i[k] = busy[k];
                    m_stb_i[k] = busy[k] & ($urandom_range(0, 3) != 0);
                end
                s_ack_i = $urandom_range(0, 1) == 1;
                s_dat_i = $urandom;
                @(negedge clk_i);
                exp_g = (own >= 0) ? (4'b0001 << own) : 4'b0000;
                chk("rnd_grant", grant_o, exp_g);
                chk("rnd_s_cyc", s_cyc_o, (own >= 0) ? m_cyc_i[own] : 1'b0);
                chk("rnd_m_ack", m_ack_o, s_ack_i ? exp_g : 4'b0000);
                chk("rnd_m_dat", m_dat_o, s_dat_i);
                if (own < 0) begin
                    own = pick(ptr, m_cyc_i);
                end else if (!m_cyc_i[own]) begin
                    ptr = own;
                    own = -1;
                end else begin
                    rem[own]--;
                    if (rem[own] == 0) busy[own] = 1'b0;
                end
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
